// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects, data-memory waits.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned LU_BUBBLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        pipe_hold,
   output logic        mem_wb_bubble,
   output logic [1:0]  state,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StLuStall = 2'd1,
      StMemWait = 2'd2
   } state_e;

   localparam logic [1:0] LuInit = 2'(LU_BUBBLES - 1);

   state_e     state_q, state_d;
   logic [1:0] lu_cnt_q, lu_cnt_d;
   logic       ret_q, ret_d;  // 1: resume LU_STALL after the memory wait

   logic lu_hit;
   logic mem_wait;
   logic act_wait;
   logic act_flush;
   logic act_lu;

   assign lu_hit = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
   assign mem_wait = mem_req && !mem_ready;

   always_comb begin
      state_d   = state_q;
      lu_cnt_d  = lu_cnt_q;
      ret_d     = ret_q;
      act_wait  = 1'b0;
      act_flush = 1'b0;
      act_lu    = 1'b0;
      unique case (state_q)
         StRun: begin
            if (mem_wait) begin
               act_wait = 1'b1;
               ret_d    = 1'b0;
               state_d  = StMemWait;
            end else if (ex_redirect) begin
               act_flush = 1'b1;
            end else if (lu_hit) begin
               act_lu = 1'b1;
               if (LU_BUBBLES > 1) begin
                  lu_cnt_d = LuInit;
                  state_d  = StLuStall;
               end
            end
         end
         StLuStall: begin
            if (mem_wait) begin
               act_wait = 1'b1;
               ret_d    = 1'b1;
               state_d  = StMemWait;
            end else if (ex_redirect) begin
               // Redirect squashes the stalled ID instruction, so the stall is moot.
               act_flush = 1'b1;
               lu_cnt_d  = 2'd0;
               state_d   = StRun;
            end else begin
               act_lu   = 1'b1;
               lu_cnt_d = lu_cnt_q - 2'd1;
               if (lu_cnt_d == 2'd0) begin
                  state_d = StRun;
               end
            end
         end
         StMemWait: begin
            // The ready cycle only lets MEM drain; pending redirect/load-use wait one cycle.
            if (mem_wait) begin
               act_wait = 1'b1;
            end else if (ret_q) begin
               act_lu  = 1'b1;
               state_d = StLuStall;
            end else begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   assign pc_en         = !(act_wait || act_lu);
   assign if_id_stall   = act_wait || act_lu;
   assign if_id_flush   = act_flush;
   assign id_ex_flush   = act_flush || act_lu;
   assign pipe_hold     = act_wait;
   assign mem_wb_bubble = act_wait;
   assign state         = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StRun;
         lu_cnt_q <= 2'd0;
         ret_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lu_cnt_q <= lu_cnt_d;
         ret_q    <= ret_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_events_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_events_q <= 32'd0;
      end else begin
         if (!pc_en) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (if_id_flush) begin
            flush_events_q <= flush_events_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`else
   assign stall_cycles = 32'h0;
   assign flush_events = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance per bubble count, directed test-plan sequences
// followed by random traffic, all checked against a cycle-level action model.
module tb_pipe_hazard_ctrl;

   localparam int ANone  = 0;
   localparam int AWait  = 1;
   localparam int AFlush = 2;
   localparam int ALu    = 3;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;

   logic [1:0]  pc_en_v, if_id_stall_v, if_id_flush_v, id_ex_flush_v, pipe_hold_v, mem_wb_bubble_v;
   logic [1:0]  state_v [2];
   logic [31:0] stall_v [2];
   logic [31:0] flush_v [2];

   int checks   = 0;
   int failures = 0;

   // Model: per instance, stage position plus remaining bubbles and return point.
   int          nb       [2] = '{1, 2};
   int          m_state  [2];
   int          m_left   [2];
   int          m_ret    [2];
   logic [31:0] m_stalls [2];
   logic [31:0] m_flush  [2];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.LU_BUBBLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en_v[0]), .if_id_stall(if_id_stall_v[0]), .if_id_flush(if_id_flush_v[0]),
      .id_ex_flush(id_ex_flush_v[0]), .pipe_hold(pipe_hold_v[0]),
      .mem_wb_bubble(mem_wb_bubble_v[0]), .state(state_v[0]), .stall_cycles(stall_v[0]),
      .flush_events(flush_v[0])
   );

   pipe_hazard_ctrl #(.LU_BUBBLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en_v[1]), .if_id_stall(if_id_stall_v[1]), .if_id_flush(if_id_flush_v[1]),
      .id_ex_flush(id_ex_flush_v[1]), .pipe_hold(pipe_hold_v[1]),
      .mem_wb_bubble(mem_wb_bubble_v[1]), .state(state_v[1]), .stall_cycles(stall_v[1]),
      .flush_events(flush_v[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] perf(input logic [31:0] v);
      return PerfEn ? v : 32'h0;
   endfunction

   // {pc_en, if_id_stall, if_id_flush, id_ex_flush, pipe_hold, mem_wb_bubble}
   function automatic logic [5:0] act_outs(input int act);
      case (act)
         AWait:   return 6'b010011;
         AFlush:  return 6'b101100;
         ALu:     return 6'b010100;
         default: return 6'b100000;
      endcase
   endfunction

   function automatic logic [5:0] dut_outs(input int k);
      return {pc_en_v[k], if_id_stall_v[k], if_id_flush_v[k], id_ex_flush_v[k], pipe_hold_v[k],
              mem_wb_bubble_v[k]};
   endfunction

   function automatic int model_act(input int k);
      bit hit;
      bit mw;
      hit = ex_mem_read && (ex_rd != 0) &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      mw  = mem_req && !mem_ready;
      if (m_state[k] == 2) return mw ? AWait : ((m_ret[k] == 1) ? ALu : ANone);
      if (mw) return AWait;
      if (ex_redirect) return AFlush;
      if (m_state[k] == 1 || hit) return ALu;
      return ANone;
   endfunction

   task automatic model_step(input int k, input int act);
      if (act == AWait || act == ALu) m_stalls[k] += 32'd1;
      if (act == AFlush) m_flush[k] += 32'd1;
      if (m_state[k] == 2) begin
         if (act != AWait) m_state[k] = m_ret[k];
      end else if (act == AWait) begin
         m_ret[k]   = m_state[k];
         m_state[k] = 2;
      end else if (m_state[k] == 1) begin
         if (act == AFlush) begin
            m_state[k] = 0;
            m_left[k]  = 0;
         end else begin
            m_left[k] -= 1;
            if (m_left[k] == 0) m_state[k] = 0;
         end
      end else if (act == ALu && nb[k] > 1) begin
         m_left[k]  = nb[k] - 1;
         m_state[k] = 1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k]  = 0;
         m_left[k]   = 0;
         m_ret[k]    = 0;
         m_stalls[k] = 32'd0;
         m_flush[k]  = 32'd0;
      end
   endtask

   task automatic quiet();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_rd = 5'd0;
      ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Apply one cycle of inputs at the negedge, check mid-cycle, then advance the model.
   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic redir, input logic req, input logic rdy, input string tag);
      id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; ex_rd = rd;
      ex_mem_read = mr; ex_redirect = redir; mem_req = req; mem_ready = rdy;
      #1;
      for (int k = 0; k < 2; k++) begin
         int act;
         act = model_act(k);
         check($sformatf("%s/lu%0d/outs", tag, nb[k]), 32'(dut_outs(k)), 32'(act_outs(act)));
         check($sformatf("%s/lu%0d/state", tag, nb[k]), 32'(state_v[k]), 32'(m_state[k]));
         check($sformatf("%s/lu%0d/stalls", tag, nb[k]), stall_v[k], perf(m_stalls[k]));
         check($sformatf("%s/lu%0d/flushes", tag, nb[k]), flush_v[k], perf(m_flush[k]));
         model_step(k, act);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   initial begin
      quiet();
      model_reset();
      do_reset();
      idle(1, "reset");

      // Load-use: 1 bubble on the first instance, 2 on the second.
      drive(5, 0, 1, 0, 5, 1, 0, 0, 0, "lu");
      idle(3, "lu_after");
      drive(7, 5, 0, 1, 5, 1, 0, 0, 0, "lu_rs2");
      idle(3, "lu_rs2_after");
      drive(0, 0, 1, 1, 0, 1, 0, 0, 0, "lu_rd0");
      drive(5, 5, 0, 0, 5, 1, 0, 0, 0, "lu_nouse");

      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0, "redir");
      idle(1, "redir_after");
      check("redir_events", flush_v[0], perf(32'd1));

      do_reset();
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, "memwait");
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, "memready");
      idle(2, "mem_after");
      check("memwait_stalls", stall_v[0], perf(32'd3));
      check("memwait_state", 32'(state_v[1]), 32'd0);

      // All three hazards at once: memory wait wins, redirect fires after ready.
      do_reset();
      for (int i = 0; i < 2; i++) drive(5, 0, 1, 0, 5, 1, 1, 1, 0, "simul_wait");
      drive(5, 0, 1, 0, 5, 1, 1, 1, 1, "simul_ready");
      drive(5, 0, 1, 0, 5, 1, 1, 0, 0, "simul_redir");
      idle(3, "simul_after");

      // Memory wait arriving mid LU_STALL freezes the bubble count.
      do_reset();
      drive(3, 0, 1, 0, 3, 1, 0, 0, 0, "lu_mem");
      for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, "lu_mem_wait");
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, "lu_mem_ready");
      idle(3, "lu_mem_after");

      // Asynchronous reset in the middle of MEM_WAIT.
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0, "rst_pre");
      for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, "rst_wait");
      check("rst_in_wait", 32'(state_v[0]), 32'd2);
      #2;
      quiet();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_async/lu%0d/state", nb[k]), 32'(state_v[k]), 32'd0);
         check($sformatf("rst_async/lu%0d/outs", nb[k]), 32'(dut_outs(k)), 32'(6'b100000));
         check($sformatf("rst_async/lu%0d/stalls", nb[k]), stall_v[k], 32'd0);
         check($sformatf("rst_async/lu%0d/flushes", nb[k]), flush_v[k], 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      drive(5, 0, 1, 0, 5, 1, 0, 0, 0, "rst_resume");
      idle(2, "rst_resume_after");

      // Random traffic on a small register space so hazards collide often.
      for (int i = 0; i < 3000; i++) begin
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It watches the ID, EX and MEM stages and drives the hold, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazards:
- load-use data hazards, with a configurable bubble count;
- branch/jump redirects resolved in EX;
- multi-cycle data-memory accesses, via a req/ready handshake.

It holds only sequencing state; it never touches datapath values.

## Interface
Parameters:
- LU_BUBBLES, 1, load-use bubbles inserted (1 or 2). Use 1 when the MEM/WB load value is forwarded to EX, otherwise 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX (target PC valid).
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register loads its next value.
- if_id_stall  out  1  IF/ID holds.
- if_id_flush  out  1  IF/ID clears to NOP.
- id_ex_flush  out  1  ID/EX clears to bubble.
- pipe_hold  out  1  ID/EX and EX/MEM hold (clock-enable low).
- mem_wb_bubble  out  1  MEM/WB captures a bubble (RegWrite=0).
- state  out  2  current state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT.
- stall_cycles  out  32  cycles with pc_en=0.
- flush_events  out  32  redirects accepted.

## Operation
Definitions:
- lu_hit = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- mem_wait = mem_req && !mem_ready.

Priority in every state: mem_wait > ex_redirect > lu_hit.

Default outputs: pc_en=1, all other control outputs 0.

State transitions and outputs:
- RUN, mem_wait:
  - outputs: pc_en=0, if_id_stall=1, pipe_hold=1, mem_wb_bubble=1;
  - save ret=RUN; next state MEM_WAIT.
- RUN, ex_redirect:
  - outputs: if_id_flush=1, id_ex_flush=1, pc_en=1 (the PC loads the target);
  - stay in RUN.
- RUN, lu_hit:
  - outputs: pc_en=0, if_id_stall=1, id_ex_flush=1;
  - if LU_BUBBLES==1, stay in RUN;
  - otherwise load lu_cnt=LU_BUBBLES-1 and go to LU_STALL.
- LU_STALL:
  - outputs: pc_en=0, if_id_stall=1, id_ex_flush=1;
  - decrement lu_cnt; go to RUN when it reaches 0.
  - If mem_wait occurs here: MEM_WAIT outputs apply, ret=LU_STALL, and lu_cnt is frozen.
- MEM_WAIT:
  - same outputs as entry while mem_wait;
  - when mem_ready rises: outputs return to default for that cycle (EX/MEM→MEM/WB advances), next state = ret.
  - If ret=LU_STALL, LU_STALL outputs apply instead of the defaults on that cycle.

Redirect while frozen:
- While pipe_hold=1, the EX instruction is frozen, so ex_redirect stays asserted and is serviced on the first non-waiting cycle.
- No redirect latch exists.

lu_cnt is 2 bits wide; ret is 1 bit.

## Timing
- Control outputs are combinational from the registered state and the current inputs.
- State, lu_cnt, ret and the counters update on the rising edge of clk.
- Reset values:
  - state=RUN, lu_cnt=0, ret=RUN, stall_cycles=0, flush_events=0;
  - outputs during reset, given quiet inputs: pc_en=1, all others 0.
- Load-use penalty is exactly LU_BUBBLES cycles. Redirect penalty is 2 cycles (IF and ID squashed), with no added state.
- Memory wait of N cycles with mem_req held gives N cycles of pc_en=0.
- Counters wrap modulo 2^32:
  - stall_cycles increments every cycle with pc_en=0;
  - flush_events increments every cycle with if_id_flush=1.
- Reset asserted mid-LU_STALL or mid-MEM_WAIT returns to RUN immediately (asynchronously) and discards lu_cnt and ret.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles and flush_events are implemented as described.
- Not defined: both outputs are tied to 32'h0 and no counter flops exist. State and control behaviour is unchanged.

## Test plan
- Load-use: LU_BUBBLES=1, ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle → pc_en=0, if_id_stall=1, id_ex_flush=1 for 1 cycle; state stays 0.
- Double bubble: LU_BUBBLES=2, same stimulus then ex_mem_read=0 → stall outputs for exactly 2 cycles; state goes 0→1→0. With ex_rd=0 instead, no stall.
- Redirect: ex_redirect=1 for 1 cycle → if_id_flush=id_ex_flush=1, pc_en=1; flush_events 0→1 (macro on).
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → pipe_hold=mem_wb_bubble=1 for 3 cycles, state=2, then RUN; stall_cycles=3.
- Simultaneous events: mem_wait, ex_redirect and lu_hit together → memory-wait outputs only; after ready, the redirect flush fires the next cycle.
- Reset: assert rst in MEM_WAIT at cycle 2 → state=0 and counters=0 immediately; after release, normal operation resumes.
